// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
//
// Input conditioning for the memory-game buttons. The four raw button levels
// are synchronized and debounced, and exactly one key is accepted per
// press/release cycle. The accepted key is held as a one-hot code. A one-cycle
// strobe marks each acceptance. A stable press of more than one key is
// rejected with its own one-cycle strobe.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a press or a
//                    release (legal 3..2^20)
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   habilita         controller permits a new play
//   botoes[3:0]      raw asynchronous button levels, 1 = pressed
//   jogada[3:0]      last accepted one-hot key, held until the next acceptance
//   jogada_feita     one-cycle strobe: jogada has just been loaded
//   jogada_invalida  one-cycle strobe: the stable press was not one-hot
//   db_estado[2:0]   current FSM state code (debug)
// -----------------------------------------------------------------------------
module detector_jogada #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic [2:0] db_estado
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ESPERA         = 3'b000,
    FILTRA_PRESS   = 3'b001,
    REGISTRA       = 3'b010,
    INVALIDA       = 3'b011,
    AGUARDA_SOLTAR = 3'b100,
    FILTRA_SOLT    = 3'b101
  } estado_t;

  estado_t       estado, estado_next;
  logic [3:0]    sync1, s;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    amostra, amostra_next;
  logic          carrega_jogada;

  // Two-flop synchronizer; only s is ever used by the FSM.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain work.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= botoes;
      s     <= sync1;
    end
  end

  // State register plus the datapath registers it steers.
  // Resetting into AGUARDA_SOLTAR means a key held through reset must be
  // released and debounced before any new press can be accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= AGUARDA_SOLTAR;
      cnt     <= '0;
      amostra <= '0;
      jogada  <= '0;
    end else begin
      estado  <= estado_next;
      cnt     <= cnt_next;
      amostra <= amostra_next;
      if (carrega_jogada) jogada <= amostra;
    end
  end

  // Next-state and datapath-update logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    estado_next    = estado;
    cnt_next       = cnt;
    amostra_next   = amostra;
    carrega_jogada = 1'b0;
    unique case (estado)
      ESPERA: begin
        if (habilita && (s != 4'b0000)) begin
          estado_next  = FILTRA_PRESS;
          amostra_next = s;
          cnt_next     = '0;
        end
      end
      FILTRA_PRESS: begin
        // Losing the key or the permission wins over reaching terminal count.
        if ((s == 4'b0000) || !habilita) begin
          estado_next = ESPERA;
        end else if (s != amostra) begin
          amostra_next = s;
          cnt_next     = '0;
        end else if (cnt == CNT_LAST) begin
          if ($onehot(amostra)) begin
            estado_next    = REGISTRA;
            carrega_jogada = 1'b1;
          end else begin
            estado_next = INVALIDA;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      REGISTRA, INVALIDA: estado_next = AGUARDA_SOLTAR;
      AGUARDA_SOLTAR: begin
        if (s == 4'b0000) begin
          estado_next = FILTRA_SOLT;
          cnt_next    = '0;
        end
      end
      FILTRA_SOLT: begin
        if (s != 4'b0000) begin
          estado_next = AGUARDA_SOLTAR;
        end else if (cnt == CNT_LAST) begin
          estado_next = ESPERA;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      // Unused codes recover through the release path, never via a strobe.
      default: estado_next = AGUARDA_SOLTAR;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    jogada_feita    = (estado == REGISTRA);
    jogada_invalida = (estado == INVALIDA);
    db_estado       = estado;
  end

endmodule

// File: tb/tb_detector_jogada.sv
// -----------------------------------------------------------------------------
// tb_detector_jogada
//
// Directed bench for detector_jogada with DEBOUNCE_CYCLES = 4. Inputs change
// 1 ns after a rising edge; outputs are sampled at that same point, which
// shows the state entered on the edge just taken. A monitor on the falling
// edge counts strobes and checks that they are exclusive and single-cycle.
// -----------------------------------------------------------------------------
module tb_detector_jogada;

  localparam logic [2:0] ST_ESPERA  = 3'b000;
  localparam logic [2:0] ST_FPRESS  = 3'b001;
  localparam logic [2:0] ST_REG     = 3'b010;
  localparam logic [2:0] ST_AGUARDA = 3'b100;
  localparam logic [2:0] ST_FSOLT   = 3'b101;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [2:0] db_estado;

  int errors = 0;
  int checks = 0;
  int n_feita = 0;
  int n_inval = 0;
  bit mon_en = 1'b0;
  logic prev_feita = 1'b0;
  logic prev_inval = 1'b0;

  detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .botoes         (botoes),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .jogada_invalida(jogada_invalida),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_now(input string name, input logic [2:0] est,
                           input logic [3:0] jog, input logic feita, input logic inval);
    check({name, ".estado"}, {29'b0, db_estado}, {29'b0, est});
    check({name, ".jogada"}, {28'b0, jogada}, {28'b0, jog});
    check({name, ".feita"}, {31'b0, jogada_feita}, {31'b0, feita});
    check({name, ".invalida"}, {31'b0, jogada_invalida}, {31'b0, inval});
  endtask

  // Strobe bookkeeping and invariants, sampled mid-cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      check("strobe_exclusive", {31'b0, jogada_feita & jogada_invalida}, 32'd0);
      check("strobe_single_cycle",
            {31'b0, (jogada_feita & prev_feita) | (jogada_invalida & prev_inval)}, 32'd0);
      if (jogada_feita) n_feita++;
      if (jogada_invalida) n_inval++;
      prev_feita = jogada_feita;
      prev_inval = jogada_invalida;
    end
  end

  // Segment: hold inputs for a number of cycles, then compare the final state,
  // the held key and the number of strobes seen during the segment.
  typedef struct {
    string      name;
    logic       hab;
    logic [3:0] bot;
    int         cycles;
    logic [2:0] exp_estado;
    logic [3:0] exp_jogada;
    int         exp_feita;
    int         exp_inval;
  } seg_t;

  seg_t segs[8];

  task automatic run_segs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      n_feita  = 0;
      n_inval  = 0;
      habilita = segs[i].hab;
      botoes   = segs[i].bot;
      tick(segs[i].cycles);
      #5; // let the monitor see the last cycle
      check({segs[i].name, ".estado"}, {29'b0, db_estado}, {29'b0, segs[i].exp_estado});
      check({segs[i].name, ".jogada"}, {28'b0, jogada}, {28'b0, segs[i].exp_jogada});
      check({segs[i].name, ".n_feita"}, n_feita, segs[i].exp_feita);
      check({segs[i].name, ".n_invalida"}, n_inval, segs[i].exp_inval);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    segs[0] = '{"multi_0110",      1'b1, 4'b0110, 10, ST_AGUARDA, 4'b0100, 0, 1};
    segs[1] = '{"release_0110",    1'b1, 4'b0000,  7, ST_ESPERA,  4'b0100, 0, 0};
    segs[2] = '{"hab0_1000",       1'b0, 4'b1000, 10, ST_ESPERA,  4'b0100, 0, 0};
    segs[3] = '{"release_1000",    1'b1, 4'b0000,  7, ST_ESPERA,  4'b1000, 0, 0};
    segs[4] = '{"held_thru_reset", 1'b1, 4'b0010, 10, ST_AGUARDA, 4'b0000, 0, 0};
    segs[5] = '{"release_0010",    1'b1, 4'b0000,  7, ST_ESPERA,  4'b0000, 0, 0};
    segs[6] = '{"repress_0010",    1'b1, 4'b0010, 10, ST_AGUARDA, 4'b0010, 1, 0};
    segs[7] = '{"release_0010b",   1'b1, 4'b0000,  7, ST_ESPERA,  4'b0010, 0, 0};

    // Reset with idle buttons, then the release filter runs into ESPERA.
    reset = 1'b1; habilita = 1'b0; botoes = 4'b0000;
    tick(2);
    check_now("reset", ST_AGUARDA, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick(1);
    check_now("idle_e1", ST_FSOLT, 4'b0000, 1'b0, 1'b0);
    tick(6);
    check_now("idle_e7", ST_ESPERA, 4'b0000, 1'b0, 1'b0);
    tick(3);
    check("idle.n_strobes", n_feita + n_inval, 0);

    // Clean press of 0001: strobe exactly on edge 7, ESPERA 7 edges after release.
    n_feita = 0;
    habilita = 1'b1; botoes = 4'b0001;
    tick(2);
    check_now("press1_e2", ST_ESPERA, 4'b0000, 1'b0, 1'b0);
    tick(1);
    check_now("press1_e3", ST_FPRESS, 4'b0000, 1'b0, 1'b0);
    tick(3);
    check_now("press1_e6", ST_FPRESS, 4'b0000, 1'b0, 1'b0);
    tick(1);
    check_now("press1_e7", ST_REG, 4'b0001, 1'b1, 1'b0);
    tick(1);
    check_now("press1_e8", ST_AGUARDA, 4'b0001, 1'b0, 1'b0);
    tick(4);
    check("press1.n_feita", n_feita, 1);
    botoes = 4'b0000;
    tick(6);
    check_now("rel1_e6", ST_FSOLT, 4'b0001, 1'b0, 1'b0);
    tick(1);
    check_now("rel1_e7", ST_ESPERA, 4'b0001, 1'b0, 1'b0);

    // Bounce: 0100 x2, 0000 x1, then 0100 held; strobe 7 edges after last rise.
    n_feita = 0;
    botoes = 4'b0100;
    tick(2);
    botoes = 4'b0000;
    tick(1);
    botoes = 4'b0100;
    tick(6);
    check_now("bounce_e6", ST_FPRESS, 4'b0001, 1'b0, 1'b0);
    tick(1);
    check_now("bounce_e7", ST_REG, 4'b0100, 1'b1, 1'b0);
    tick(3);
    check("bounce.n_feita", n_feita, 1);
    botoes = 4'b0000;
    tick(7);
    check_now("bounce_rel", ST_ESPERA, 4'b0100, 1'b0, 1'b0);

    // Two-key press rejected, then key held while habilita is low.
    run_segs(0, 2);

    // habilita rises with 1000 already held: strobe on edge 5.
    n_feita = 0;
    habilita = 1'b1;
    tick(4);
    check_now("hab_rise_e4", ST_FPRESS, 4'b0100, 1'b0, 1'b0);
    tick(1);
    check_now("hab_rise_e5", ST_REG, 4'b1000, 1'b1, 1'b0);
    tick(1);
    run_segs(3, 3);

    // Reset while filtering 0010; the held key must not be accepted.
    botoes = 4'b0010;
    tick(4);
    check_now("pre_reset", ST_FPRESS, 4'b1000, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1);
    check_now("mid_reset", ST_AGUARDA, 4'b0000, 1'b0, 1'b0);
    reset = 1'b0;
    run_segs(4, 7);

    // habilita drops in the cycle the counter reaches terminal: no strobe.
    n_feita = 0;
    habilita = 1'b1; botoes = 4'b0001;
    tick(6);
    check_now("hab_drop_e6", ST_FPRESS, 4'b0010, 1'b0, 1'b0);
    habilita = 1'b0;
    tick(1);
    check_now("hab_drop_e7", ST_ESPERA, 4'b0010, 1'b0, 1'b0);
    tick(4);
    check("hab_drop.n_feita", n_feita, 0);
    botoes = 4'b0000;
    tick(3);
    check_now("hab_drop_end", ST_ESPERA, 4'b0010, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
